// File: rtl/mem_master_pkg.sv
// Shared definitions for the RAM initiator: FSM state encodings, fault codes
// and small address helpers.
package mem_master_pkg;

  // Access FSM states (2-bit encoding shared with older RAM-side tooling)
  localparam logic [1:0] MS_IDLE  = 2'd0;
  localparam logic [1:0] MS_ISSUE = 2'd1;
  localparam logic [1:0] MS_WAIT  = 2'd2;
  localparam logic [1:0] MS_RESP  = 2'd3;

  // Fault codes reported on fault_code
  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_ALIGN = 2'b01;
  localparam logic [1:0] FC_EXC   = 2'b10;
  localparam logic [1:0] FC_TMO   = 2'b11;

  // Width of the WAIT-state cycle counter; covers TIMEOUT up to 255
  localparam int TMO_CNT_W = 8;

  // CPU address to RAM word address. Byte mode drops the two offset bits
  // without wrapping; the RAM performs its own range check.
  function automatic logic [31:0] word_addr(input logic [31:0] addr,
                                            input logic        byte_mode);
    return byte_mode ? {2'b00, addr[31:2]} : addr;
  endfunction

  // Only byte addresses can be misaligned
  function automatic logic misaligned(input logic [1:0] addr_lsb,
                                      input logic       byte_mode);
    return byte_mode && (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_tmo_cnt.sv
// Clear/enable cycle counter with a terminal-count flag. Used to bound the
// number of cycles the initiator waits for a RAM response.
module mem_tmo_cnt
  import mem_master_pkg::*;
#(
  parameter logic [TMO_CNT_W-1:0] TERM = 8'd15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMO_CNT_W-1:0] count_reg;

  // Count enabled cycles; clear has priority so each wait starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Flag is valid in the cycle the counter holds the terminal value
  always_comb begin
    tc = (count_reg == TERM);
  end

endmodule

// File: rtl/mem_master.sv
// Initiator for the word-addressed RAM rdy/exc handshake. Accepts one CPU
// load/store at a time, strobes the RAM, waits for completion, exception or
// timeout, then reports done or fault for one cycle. All outputs registered.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int BYTE_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [31:0]       r_addr,
  output logic [31:0]       w_addr,
  output logic [DATA_W-1:0] w_line,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] r_line,
  input  logic              rrdy,
  input  logic              wrdy,
  input  logic              exc
);

  // Last WAIT cycle index before a timeout is declared
  localparam logic [TMO_CNT_W-1:0] TMO_TERM = TMO_CNT_W'(TIMEOUT - 1);
  localparam logic BYTE_MODE = (BYTE_ADDR != 0);

  logic [1:0]  state_reg;
  logic        we_reg;
  logic        tmo_tc;
  logic        req_misaligned;
  logic [31:0] req_word_addr;
  logic        rdy_seen;

  // Counter runs only while waiting; any other state holds it at zero
  mem_tmo_cnt #(
    .TERM (TMO_TERM)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_reg != MS_WAIT),
    .en    (state_reg == MS_WAIT),
    .tc    (tmo_tc)
  );

  // Decode the incoming request and the completion for the current direction
  always_comb begin
    req_word_addr  = word_addr(cpu_addr, BYTE_MODE);
    req_misaligned = misaligned(cpu_addr[1:0], BYTE_MODE);
    rdy_seen       = we_reg ? wrdy : rrdy;
  end

  // Access FSM; every CPU- and RAM-facing output is a register of this block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= MS_IDLE;
      we_reg     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      cpu_rdata  <= '0;
      r_addr     <= '0;
      w_addr     <= '0;
      w_line     <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
    end else begin
      case (state_reg)
        MS_IDLE: begin
          // Late rdy/exc from an aborted access are simply not looked at here
          if (cpu_req) begin
            busy   <= 1'b1;
            we_reg <= cpu_we;
            if (req_misaligned) begin
              fault      <= 1'b1;
              fault_code <= FC_ALIGN;
              state_reg  <= MS_RESP;
            end else begin
              if (cpu_we) begin
                write  <= 1'b1;
                w_addr <= req_word_addr;
                w_line <= cpu_wdata;
              end else begin
                read   <= 1'b1;
                r_addr <= req_word_addr;
              end
              state_reg <= MS_ISSUE;
            end
          end
        end

        MS_ISSUE: begin
          // RAM handshake inputs still describe the previous access here
          state_reg <= MS_WAIT;
        end

        MS_WAIT: begin
          // Completion wins over a (possibly stale) exception level
          if (rdy_seen) begin
            read       <= 1'b0;
            write      <= 1'b0;
            done       <= 1'b1;
            fault_code <= FC_NONE;
            if (!we_reg) begin
              cpu_rdata <= r_line;
            end
            state_reg <= MS_RESP;
          end else if (exc) begin
            read       <= 1'b0;
            write      <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FC_EXC;
            state_reg  <= MS_RESP;
          end else if (tmo_tc) begin
            read       <= 1'b0;
            write      <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FC_TMO;
            state_reg  <= MS_RESP;
          end
        end

        MS_RESP: begin
          // done/fault live for exactly this cycle
          done      <= 1'b0;
          fault     <= 1'b0;
          busy      <= 1'b0;
          state_reg <= MS_IDLE;
        end

        default: begin
          state_reg <= MS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a small behavioural RAM (1024 words).
module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        busy, done, fault;
  logic [1:0]  fault_code;
  logic [31:0] cpu_rdata, r_addr, w_addr, w_line, r_line;
  logic        rd, wr, rrdy, wrdy, exc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_master #(
    .DATA_W    (32),
    .TIMEOUT   (16),
    .BYTE_ADDR (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .cpu_rdata  (cpu_rdata),
    .r_addr     (r_addr),
    .w_addr     (w_addr),
    .w_line     (w_line),
    .read       (rd),
    .write      (wr),
    .r_line     (r_line),
    .rrdy       (rrdy),
    .wrdy       (wrdy),
    .exc        (exc)
  );

  // Behavioural RAM: answers a new strobe one cycle later, sticky exc on range error
  logic [31:0] ram [0:1023];
  logic [31:0] rdata_q = '0;
  logic        rrdy_q = 1'b0;
  logic        wrdy_q = 1'b0;
  logic        exc_q = 1'b0;
  logic        ram_mute = 1'b0;
  logic        inj_rrdy = 1'b0;

  always @(posedge clk) begin
    rrdy_q <= 1'b0;
    wrdy_q <= 1'b0;
    if (!ram_mute) begin
      if (rd && !rrdy_q) begin
        if (r_addr < 32'd1024) begin
          rdata_q <= ram[r_addr[9:0]];
          rrdy_q  <= 1'b1;
          exc_q   <= 1'b0;
        end else begin
          exc_q <= 1'b1;
        end
      end
      if (wr && !wrdy_q) begin
        if (w_addr < 32'd1024) begin
          ram[w_addr[9:0]] <= w_line;
          wrdy_q <= 1'b1;
          exc_q  <= 1'b0;
        end else begin
          exc_q <= 1'b1;
        end
      end
    end
  end

  assign rrdy   = rrdy_q | inj_rrdy;
  assign wrdy   = wrdy_q;
  assign exc    = exc_q;
  // Junk pattern stands in for the undriven bus outside the rrdy cycle
  assign r_line = rrdy_q ? rdata_q : 32'hBAD0_BAD0;

  // Event counters sampled on the falling edge
  int   rd_rise = 0, wr_rise = 0, done_cnt = 0, fault_cnt = 0, both_cnt = 0;
  logic rd_q = 1'b0, wr_q = 1'b0;

  always @(negedge clk) begin
    if (rd && !rd_q) rd_rise++;
    if (wr && !wr_q) wr_rise++;
    if (done) done_cnt++;
    if (fault) fault_cnt++;
    if (rd && wr) both_cnt++;
    rd_q = rd;
    wr_q = wr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One access; cyc=1 is the cycle cpu_req is presented, returns on done/fault
  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output int cyc);
    int guard;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
      cpu_req = 1'b0;
    end while (!done && !fault && cyc < 40);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int r0, w0, d0, f0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({rd, wr}), 64'd0);
    chk("rst_flags", 64'({done, fault, fault_code}), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_addrs", {r_addr, w_addr}, 64'd0);
    chk("rst_wline", 64'(w_line), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: store then load at byte 0x10 (word 4)
    access(1'b1, 32'h10, 32'hDEADBEEF, cyc);
    $display("T1 store @0x10 cyc=%0d done=%0b", cyc, done);
    chk("t1_st_cyc", 64'(cyc), 64'd4);
    chk("t1_st_flags", 64'({done, fault}), 64'b10);
    chk("t1_st_waddr", 64'(w_addr), 64'd4);
    chk("t1_st_strobe", 64'({rd, wr}), 64'd0);
    chk("t1_ram4", 64'(ram[4]), 64'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0, cyc);
    $display("T1 load @0x10 cyc=%0d rdata=%h", cyc, cpu_rdata);
    chk("t1_ld_cyc", 64'(cyc), 64'd4);
    chk("t1_ld_flags", 64'({done, fault, fault_code}), 64'b1000);
    chk("t1_ld_raddr", 64'(r_addr), 64'd4);
    chk("t1_ld_rdata", 64'(cpu_rdata), 64'hDEADBEEF);

    // 2: misaligned load
    r0 = rd_rise; w0 = wr_rise;
    access(1'b0, 32'h1002, 32'h0, cyc);
    $display("T2 load @0x1002 cyc=%0d code=%b", cyc, fault_code);
    chk("t2_cyc", 64'(cyc), 64'd2);
    chk("t2_flags", 64'({done, fault, fault_code}), 64'b0101);
    @(negedge clk);
    chk("t2_pulse_end", 64'({fault, busy}), 64'd0);
    chk("t2_code_held", 64'(fault_code), 64'b01);
    chk("t2_no_strobe", 64'({rd_rise - r0, wr_rise - w0}), 64'd0);
    chk("t2_rdata_held", 64'(cpu_rdata), 64'hDEADBEEF);

    // 3: RAM range exception, then a good load that ignores the stale exc
    access(1'b1, 32'h0, 32'h12345678, cyc);
    chk("t3_st_done", 64'({done, fault}), 64'b10);
    access(1'b0, 32'h1000, 32'h0, cyc);
    $display("T3 load @0x1000 cyc=%0d code=%b", cyc, fault_code);
    chk("t3_exc_cyc", 64'(cyc), 64'd4);
    chk("t3_exc_flags", 64'({done, fault, fault_code}), 64'b0110);
    chk("t3_exc_raddr", 64'(r_addr), 64'd1024);
    access(1'b0, 32'h0, 32'h0, cyc);
    $display("T3 load @0x0 cyc=%0d rdata=%h", cyc, cpu_rdata);
    chk("t3_ok_cyc", 64'(cyc), 64'd4);
    chk("t3_ok_flags", 64'({done, fault, fault_code}), 64'b1000);
    chk("t3_ok_rdata", 64'(cpu_rdata), 64'h12345678);

    // 4: silent RAM -> timeout after 16 WAIT cycles
    ram_mute = 1'b1;
    access(1'b0, 32'h10, 32'h0, cyc);
    $display("T4 timeout load cyc=%0d code=%b", cyc, fault_code);
    chk("t4_cyc", 64'(cyc), 64'd19);
    chk("t4_flags", 64'({done, fault, fault_code}), 64'b0111);
    chk("t4_read_low", 64'(rd), 64'd0);
    ram_mute = 1'b0;

    // 5: asynchronous reset during WAIT, then a late rrdy
    wait_idle();
    ram_mute = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_read_pre", 64'({rd, busy}), 64'b11);
    #2 rst_n = 1'b0;
    #1;
    $display("T5 async reset read=%0b busy=%0b", rd, busy);
    chk("t5_rst_read", 64'(rd), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ram_mute = 1'b0;
    d0 = done_cnt; f0 = fault_cnt;
    inj_rrdy = 1'b1;
    @(negedge clk);
    inj_rrdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_late_rrdy", 64'({done_cnt - d0, fault_cnt - f0}), 64'd0);
    chk("t5_idle", 64'({busy, rd, cpu_rdata}), 64'd0);
    access(1'b0, 32'h10, 32'h0, cyc);
    $display("T5 load after reset cyc=%0d rdata=%h", cyc, cpu_rdata);
    chk("t5_ok_cyc", 64'(cyc), 64'd4);
    chk("t5_ok_rdata", 64'({done, cpu_rdata}), {31'd0, 1'b1, 32'hDEADBEEF});

    // 6: cpu_req held high -> five serialized loads in 20 cycles
    wait_idle();
    r0 = rd_rise; w0 = wr_rise; d0 = done_cnt; f0 = fault_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    repeat (20) @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("T6 held req reads=%0d dones=%0d", rd_rise - r0, done_cnt - d0);
    chk("t6_reads", 64'(rd_rise - r0), 64'd5);
    chk("t6_dones", 64'(done_cnt - d0), 64'd5);
    chk("t6_writes_faults", 64'({wr_rise - w0, fault_cnt - f0}), 64'd0);
    chk("t6_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    chk("never_both_strobes", 64'(both_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
